seqdet_evt_counter: RTL

- Downstream consumer of the 1011 sequence detector's single-cycle match pulse (check_vld).
- Counts match pulses over fixed windows of WIN_LEN clock cycles.
- At each window close, publishes a report (count, saturation flag, drop flag) on a one-entry valid/ready output register.
- Lets software or the next stage sample match rate without observing every pulse.

---
 rtl/seqdet_pkg.sv | 18 +
 rtl/seqdet_win_timer.sv | 31 +++
 rtl/seqdet_evt_counter.sv | 114 +++++++++++
 3 files changed

// File: rtl/seqdet_pkg.sv
// Shared types and defaults for the 1011-detector match-rate counter.
package seqdet_pkg;

    localparam int SEQDET_CNT_W   = 8;
    localparam int SEQDET_WIN_LEN = 256;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seqdet_cnt_state_t;

    typedef struct packed {
        logic [SEQDET_CNT_W-1:0] count;
        logic                    sat;
        logic                    drop;
    } seqdet_rpt_t;

endpackage

// File: rtl/seqdet_win_timer.sv
// Modulo-WIN_LEN window timer; win_last marks the closing cycle of each window.
module seqdet_win_timer
    import seqdet_pkg::*;
#(
    parameter int WIN_LEN = SEQDET_WIN_LEN,
    parameter int WIN_W   = $clog2(WIN_LEN)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic win_last
);

    localparam logic [WIN_W-1:0] LAST_IDX = WIN_W'(WIN_LEN - 1);

    logic [WIN_W-1:0] win_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_reg <= '0;
        end else if (clr) begin
            win_cnt_reg <= '0;
        end else if (run) begin
            win_cnt_reg <= (win_cnt_reg == LAST_IDX) ? '0 : win_cnt_reg + 1'b1;
        end
    end

    assign win_last = run && (win_cnt_reg == LAST_IDX);

endmodule

// File: rtl/seqdet_evt_counter.sv
// Counts detector match pulses per WIN_LEN-cycle window and publishes one
// report per window through a single-entry valid/ready register.
module seqdet_evt_counter
    import seqdet_pkg::*;
#(
    parameter int CNT_W   = SEQDET_CNT_W,
    parameter int WIN_LEN = SEQDET_WIN_LEN,
    parameter int WIN_W   = $clog2(WIN_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             check_vld,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_count,
    output logic             rpt_sat,
    output logic             rpt_drop
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    seqdet_cnt_state_t state_reg;
    logic [CNT_W-1:0]  match_cnt_reg;
    logic              sat_reg;
    logic              drop_pending_reg;
    logic              rpt_valid_reg;
    logic [CNT_W-1:0]  rpt_count_reg;
    logic              rpt_sat_reg;
    logic              rpt_drop_reg;

    logic [CNT_W-1:0]  match_cnt_next;
    logic              sat_next;
    logic              running;
    logic              win_last;

    // A RUN cycle with en low is the abort cycle; it neither counts nor advances the timer.
    assign running = (state_reg == RUN) && en;

    seqdet_win_timer #(
        .WIN_LEN (WIN_LEN),
        .WIN_W   (WIN_W)
    ) u_win_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (running),
        .clr      (!running),
        .win_last (win_last)
    );

    always_comb begin
        match_cnt_next = match_cnt_reg;
        sat_next       = sat_reg;
        if (check_vld) begin
            if (match_cnt_reg == CNT_MAX) begin
                sat_next = 1'b1;
            end else begin
                match_cnt_next = match_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            match_cnt_reg    <= '0;
            sat_reg          <= 1'b0;
            drop_pending_reg <= 1'b0;
            rpt_valid_reg    <= 1'b0;
            rpt_count_reg    <= '0;
            rpt_sat_reg      <= 1'b0;
            rpt_drop_reg     <= 1'b0;
        end else begin
            if (state_reg == IDLE) begin
                match_cnt_reg <= '0;
                sat_reg       <= 1'b0;
                if (en) begin
                    state_reg <= RUN;
                end
            end else if (!en) begin
                state_reg     <= IDLE;
                match_cnt_reg <= '0;
                sat_reg       <= 1'b0;
            end else if (win_last) begin
                match_cnt_reg <= '0;
                sat_reg       <= 1'b0;
            end else begin
                match_cnt_reg <= match_cnt_next;
                sat_reg       <= sat_next;
            end

            // The closing cycle's pulse is included via the _next values.
            if (win_last) begin
                if (!rpt_valid_reg || rpt_ready) begin
                    rpt_valid_reg    <= 1'b1;
                    rpt_count_reg    <= match_cnt_next;
                    rpt_sat_reg      <= sat_next;
                    rpt_drop_reg     <= drop_pending_reg;
                    drop_pending_reg <= 1'b0;
                end else begin
                    drop_pending_reg <= 1'b1;
                end
            end else if (rpt_ready) begin
                rpt_valid_reg <= 1'b0;
            end
        end
    end

    assign rpt_valid = rpt_valid_reg;
    assign rpt_count = rpt_count_reg;
    assign rpt_sat   = rpt_sat_reg;
    assign rpt_drop  = rpt_drop_reg;

endmodule
